dmux4way16_stream: RTL and testbench

//  Inverse of the 4-way 16-bit word multiplexer. Routes one input word stream to one of four output channels (A..D).
//  in_sel picks the channel. Each channel has a one-entry registered buffer with valid/ready flow control.

---
 rtl/dmux_pkg.sv | 17 +
 rtl/dmux_chan_buf.sv | 34 +++
 rtl/dmux4way16_stream.sv | 76 +++++++
 tb/tb_dmux4way16_stream.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared definitions for the 4-way word stream demultiplexer.
// Channel indices, the select type and the select-to-one-hot decode.
package dmux_pkg;

  localparam int DMUX_WAYS = 4;
  localparam int CH_A      = 0;
  localparam int CH_B      = 1;
  localparam int CH_C      = 2;
  localparam int CH_D      = 3;

  typedef logic [1:0] chan_sel_t;

  function automatic logic [DMUX_WAYS-1:0] sel_decode(input chan_sel_t sel);
    return DMUX_WAYS'(1) << sel;
  endfunction

endpackage

// File: rtl/dmux_chan_buf.sv
// One-entry registered channel buffer: a load fills it (replacing any drained word),
// a drain without load empties it. Data holds its last value while empty.
module dmux_chan_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;

  // Stage p1: buffer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (load) begin
      data_p1 <= load_data;
      vld_p1  <= 1'b1;
    end else if (vld_p1 && drain_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign data  = data_p1;
  assign valid = vld_p1;

endmodule

// File: rtl/dmux4way16_stream.sv
// Routes one valid/ready word stream to one of four buffered output channels.
// Optional per-channel saturating transfer counters when DMUX_STATS_EN is defined.
module dmux4way16_stream
  import dmux_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  chan_sel_t              in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_A,
  output logic [WIDTH-1:0]       out_B,
  output logic [WIDTH-1:0]       out_C,
  output logic [WIDTH-1:0]       out_D,
  output logic [DMUX_WAYS-1:0]   out_valid,
  input  logic [DMUX_WAYS-1:0]   out_ready
`ifdef DMUX_STATS_EN
  ,
  output logic [DMUX_WAYS*CNT_WIDTH-1:0] cnt_flat
`endif
);

  logic [WIDTH-1:0]     buf_data [DMUX_WAYS];
  logic [DMUX_WAYS-1:0] buf_vld;
  logic                 accept_p0;
  logic [DMUX_WAYS-1:0] load_p0;

  // Stage p0: handshake and select decode; in_ready never depends on in_valid or in_data
  assign in_ready  = ~buf_vld[in_sel] | out_ready[in_sel];
  assign accept_p0 = in_valid & in_ready;
  assign load_p0   = accept_p0 ? sel_decode(in_sel) : '0;

  for (genvar k = 0; k < DMUX_WAYS; k++) begin : g_chan
    dmux_chan_buf #(.WIDTH(WIDTH)) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load_p0[k]),
      .load_data   (in_data),
      .drain_ready (out_ready[k]),
      .data        (buf_data[k]),
      .valid       (buf_vld[k])
    );
  end

  assign out_A     = buf_data[CH_A];
  assign out_B     = buf_data[CH_B];
  assign out_C     = buf_data[CH_C];
  assign out_D     = buf_data[CH_D];
  assign out_valid = buf_vld;

`ifdef DMUX_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  for (genvar k = 0; k < DMUX_WAYS; k++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_p1;

    // Stage p1: per-channel accepted-word counter
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_p1 <= '0;
      end else if (load_p0[k]) begin
        cnt_p1 <= sat_inc(cnt_p1);
      end
    end

    assign cnt_flat[k*CNT_WIDTH +: CNT_WIDTH] = cnt_p1;
  end
`endif

endmodule

// File: tb/tb_dmux4way16_stream.sv
// Directed bench for dmux4way16_stream: vector table plus reset, throughput and stats sequences.
// Stats sequence is compiled only when DMUX_STATS_EN is defined.
module tb_dmux4way16_stream;
  import dmux_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  chan_sel_t        in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_A, out_B, out_C, out_D;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
`ifdef DMUX_STATS_EN
  logic [4*CNT_WIDTH-1:0] cnt_flat;
`endif

  always #5 clk = ~clk;

  dmux4way16_stream #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_A     (out_A),
    .out_B     (out_B),
    .out_C     (out_C),
    .out_D     (out_D),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DMUX_STATS_EN
    ,
    .cnt_flat  (cnt_flat)
`endif
  );

  typedef struct {
    logic [15:0] data;
    logic [1:0]  sel;
    logic        vld;
    logic [3:0]  rdy;
    logic        exp_in_rdy;
    logic [3:0]  exp_ov;
    logic [1:0]  chk_ch;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs [11];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] chan_out(input logic [1:0] ch);
    case (ch)
      2'd0:    return out_A;
      2'd1:    return out_B;
      2'd2:    return out_C;
      default: return out_D;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // data   sel  vld  rdy      in_rdy ov       ch  out
    vecs[0]  = '{16'h1111, 2'd0, 1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 16'h1111};
    vecs[1]  = '{16'h2222, 2'd1, 1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 16'h2222};
    vecs[2]  = '{16'h3333, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 16'h3333};
    vecs[3]  = '{16'h4444, 2'd3, 1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 16'h4444};
    vecs[4]  = '{16'hBEEF, 2'd2, 1'b1, 4'b1011, 1'b1, 4'b0100, 2'd2, 16'hBEEF};
    vecs[5]  = '{16'hCAFE, 2'd2, 1'b1, 4'b1011, 1'b0, 4'b0100, 2'd2, 16'hBEEF};
    vecs[6]  = '{16'h0A0A, 2'd0, 1'b1, 4'b1011, 1'b1, 4'b0101, 2'd0, 16'h0A0A};
    vecs[7]  = '{16'hCAFE, 2'd2, 1'b1, 4'b1010, 1'b0, 4'b0101, 2'd2, 16'hBEEF};
    vecs[8]  = '{16'hCAFE, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 16'hCAFE};
    vecs[9]  = '{16'h0000, 2'd2, 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd2, 16'hCAFE};
    vecs[10] = '{16'h0000, 2'd3, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd3, 16'h4444};

    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    #12;
    chk("reset_ov", {28'd0, out_valid}, 32'h0);
    chk("reset_outs", {out_A | out_B | out_C | out_D}, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      in_data   = vecs[i].data;
      in_sel    = vecs[i].sel;
      in_valid  = vecs[i].vld;
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_in_rdy});
      tick();
      chk($sformatf("vec%0d_out_valid", i), {28'd0, out_valid}, {28'd0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_out_data", i), {16'd0, chan_out(vecs[i].chk_ch)}, {16'd0, vecs[i].exp_out});
    end
    chk("hold_A", {16'd0, out_A}, 32'h0A0A);
    chk("hold_B", {16'd0, out_B}, 32'h2222);

    // Fill B with its consumer stalled, then reset asynchronously mid-cycle
    in_data = 16'h5555; in_sel = 2'd1; in_valid = 1'b1; out_ready = 4'b0000;
    tick();
    in_valid = 1'b0;
    chk("b_full_ov", {28'd0, out_valid}, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ov", {28'd0, out_valid}, 32'h0);
    chk("async_rst_A", {16'd0, out_A}, 32'h0);
    chk("async_rst_B", {16'd0, out_B}, 32'h0);
    chk("async_rst_C", {16'd0, out_C}, 32'h0);
    chk("async_rst_D", {16'd0, out_D}, 32'h0);
    #1;
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk($sformatf("post_rst_in_ready_sel%0d", s), {31'd0, in_ready}, 32'h1);
    end
    tick();
    chk("post_rst_ov", {28'd0, out_valid}, 32'h0);

    // Back-to-back stream on D with the consumer always ready
    out_ready = 4'b1000;
    in_sel    = 2'd3;
    in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 16'h1000 + 16'(i);
      #1;
      chk($sformatf("tput_in_ready_%0d", i), {31'd0, in_ready}, 32'h1);
      tick();
      chk($sformatf("tput_word_%0d", i), {15'd0, out_valid[3], out_D}, {15'd0, 1'b1, 16'h1000 + 16'(i)});
    end
    in_valid = 1'b0;
    tick();
    chk("tput_drained_ov", {28'd0, out_valid}, 32'h0);

`ifdef DMUX_STATS_EN
    rst_n = 1'b0;
    #2;
    chk("stats_reset", cnt_flat, 32'h0);
    rst_n = 1'b1;
    tick();
    out_ready = 4'b1111;
    in_sel    = 2'd0;
    in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = 16'(i);
      tick();
      if (i == 253) chk("stats_A_254", cnt_flat, 32'h0000_00FE);
    end
    in_valid = 1'b0;
    tick();
    chk("stats_A_saturated", cnt_flat, 32'h0000_00FF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
